// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small byte FIFO on a valid/ready port feeding
// a start/data/stop serializer whose line output is always taken from a flop.
module uart_tx_buffered #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          txd,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud_cnt;
  logic          push;
  logic          pop;
  logic          baud_done;
  logic          next_idle;
  logic [AW:0]   count_next;

  assign ready_o   = (count_o != DEPTH_C);
  assign push      = valid_i & ready_o;
  assign baud_done = (baud_cnt == BAUD_LAST);
  // Pop decisions use the pre-push count, so a byte landing at the very end of a
  // stop bit waits one IDLE cycle rather than racing the pointer update.
  assign pop       = (count_o != '0) && ((state == IDLE) || (state == STOP && baud_done));
  assign next_idle = ((state == IDLE) && !pop) || ((state == STOP) && baud_done && !pop);

  always_comb begin
    count_next = count_o;
    case ({push, pop})
      2'b10:   count_next = count_o + CNT_ONE;
      2'b01:   count_next = count_o - CNT_ONE;
      default: count_next = count_o;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count_o <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy_o   <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      busy_o <= !next_idle || (count_next != '0);
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            state    <= START;
            txd      <= 1'b0;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            bit_idx  <= '0;
            txd      <= shift[0];
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered with 4 clocks per bit and a 4-entry FIFO;
// a free-running reference decoder recovers bytes from txd for ordering checks.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       txd;
  logic       busy_o;
  logic [2:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit dec_en   = 1'b0;
  bit seen_full;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;   // bit i = i-th symbol on the line: start, d0..d7, stop
  } vec_t;
  vec_t vecs [7];

  uart_tx_buffered #(.CLOCKS_PER_BAUD(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .txd(txd), .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int t;
    t = 0;
    while (busy_o !== 1'b0 && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    check(name, busy_o, 0);
  endtask

  task automatic compare_rx(input string name);
    check({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({name, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Holds valid_i with b until the DUT accepts it; ready at a negedge is what the next posedge sees.
  task automatic push_byte(input logic [7:0] b);
    bit r;
    bit done;
    done = 1'b0;
    valid_i = 1'b1;
    data_i  = b;
    for (int t = 0; t < 300 && !done; t++) begin
      r = ready_o;
      check("ready_vs_count", ready_o, (count_o != 3'd4));
      if (count_o == 3'd4) seen_full = 1'b1;
      @(negedge clk);
      done = r;
    end
    check("push_accepted", done, 1);
    valid_i = 1'b0;
    exp_q.push_back(b);
  endtask

  initial begin : decoder
    logic [39:0] samp;
    logic [7:0]  b;
    bit          abort;
    forever begin
      @(negedge clk);
      if (dec_en && rst_n === 1'b1 && txd === 1'b0) begin
        samp  = '0;
        abort = 1'b0;
        for (int s = 1; s < 40; s++) begin
          @(negedge clk);
          if (!dec_en || rst_n !== 1'b1) begin
            abort = 1'b1;
            break;
          end
          samp[s] = txd;
        end
        if (!abort) begin
          for (int k = 0; k < 10; k++)
            check("bit_width", samp[4*k+1 +: 3], {3{samp[4*k]}});
          check("stop_bit", samp[36], 1);
          for (int k = 0; k < 8; k++) b[k] = samp[4*(k+1)];
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin
    int idx [3];
    int gap;
    logic [7:0] rb;

    vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{8'h55, 10'b1_0101_0101_0};
    vecs[4] = '{8'h3C, 10'b1_0011_1100_0};
    vecs[5] = '{8'h80, 10'b1_1000_0000_0};
    vecs[6] = '{8'h01, 10'b1_0000_0001_0};

    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; seen_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ready", ready_o, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    dec_en = 1'b1;

    // Single frames from idle, exact cycle-by-cycle line image
    for (int v = 0; v < 7; v++) begin
      valid_i = 1'b1;
      data_i  = vecs[v].data;
      @(negedge clk);
      valid_i = 1'b0;
      check("pre_txd", txd, 1);
      check("pre_count", count_o, 1);
      check("pre_busy", busy_o, 1);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        check("frame_txd", txd, vecs[v].bits[k/4]);
        check("frame_busy", busy_o, 1);
      end
      @(negedge clk);
      check("post_busy", busy_o, 0);
      check("post_txd", txd, 1);
      check("post_count", count_o, 0);
      exp_q.push_back(vecs[v].data);
      repeat (3) @(negedge clk);
    end
    compare_rx("single");

    // Back-to-back frames; the second push coincides with the first pop
    idx = '{1, 2, 3};
    valid_i = 1'b1;
    data_i  = 8'h00;
    @(negedge clk);
    check("b2b_count_first", count_o, 1);
    data_i = 8'hFF;
    @(negedge clk);
    check("push_pop_count", count_o, 1);
    data_i = 8'h55;
    for (int k = 0; k < 120; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        valid_i = 1'b0;
        check("b2b_count_two", count_o, 2);
      end
      check("b2b_txd", txd, vecs[idx[k/40]].bits[(k%40)/4]);
    end
    @(negedge clk);
    check("b2b_end_busy", busy_o, 0);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    compare_rx("b2b");
    repeat (3) @(negedge clk);

    // Backpressure: six bytes with valid held high
    seen_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rb = 8'h11 * (i + 1);
      push_byte(rb);
    end
    check("full_seen", seen_full, 1);
    wait_idle("bp_idle", 400);
    compare_rx("backpressure");
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a data bit with two bytes queued
    valid_i = 1'b1;
    data_i  = 8'h3C;
    @(negedge clk);
    data_i = 8'hAA;
    @(negedge clk);
    data_i = 8'hBB;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_txd_low", txd, 0);
    check("mid_count", count_o, 2);
    dec_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_txd", txd, 1);
    check("async_count", count_o, 0);
    check("async_busy", busy_o, 0);
    check("async_ready", ready_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("after_rst_txd", txd, 1);
      check("after_rst_busy", busy_o, 0);
    end
    rx_q.delete();
    exp_q.delete();
    dec_en = 1'b1;

    // Random stream with random gaps
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      rb = 8'($urandom);
      push_byte(rb);
    end
    wait_idle("rand_idle", 400);
    compare_rx("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
